// File: rtl/calc_pkg.sv
// Shared calculator constants: key codes, ALU op codes and the ANS marker value.
// Also holds the key-to-op decode used by operand_entry.
package calc_pkg;

  localparam int AC_N = 3;

  localparam logic [AC_N-1:0] AC_AD = 3'd0;
  localparam logic [AC_N-1:0] AC_SB = 3'd1;
  localparam logic [AC_N-1:0] AC_AN = 3'd2;
  localparam logic [AC_N-1:0] AC_OR = 3'd3;
  localparam logic [AC_N-1:0] AC_LS = 3'd4;

  localparam logic [15:0] IC_ANS = 16'hFFFF;

  localparam logic [4:0] KC_ADD    = 5'h10;
  localparam logic [4:0] KC_SUB    = 5'h11;
  localparam logic [4:0] KC_AND    = 5'h12;
  localparam logic [4:0] KC_OR     = 5'h13;
  localparam logic [4:0] KC_LESS   = 5'h14;
  localparam logic [4:0] KC_EQUALS = 5'h15;
  localparam logic [4:0] KC_CLEAR  = 5'h16;
  localparam logic [4:0] KC_ANS    = 5'h17;
  localparam logic [4:0] KC_BKSP   = 5'h18;

  function automatic logic is_op_key(input logic [4:0] code);
    return (code >= KC_ADD) && (code <= KC_LESS);
  endfunction

  function automatic logic [AC_N-1:0] op_of_key(input logic [4:0] code);
    logic [AC_N-1:0] op;
    case (code)
      KC_ADD:  op = AC_AD;
      KC_SUB:  op = AC_SB;
      KC_AND:  op = AC_AN;
      KC_OR:   op = AC_OR;
      KC_LESS: op = AC_LS;
      default: op = AC_AN;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/digit_accum.sv
// One hex operand being typed: shift-in of digits, 4-digit limit, ANS load and backspace.
// value_next is exposed so the owner can mirror an edit into its output register on the same edge.
module digit_accum
  import calc_pkg::*;
#(
  parameter logic [15:0] ANS_CODE = IC_ANS
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        clr,
  input  logic        ans,
  input  logic        digit_en,
  input  logic [3:0]  digit,
  input  logic        bksp,
  output logic [15:0] value,
  output logic [15:0] value_next,
  output logic        full,
  output logic        empty
);

  logic [15:0] value_reg;
  logic [2:0]  count_reg, count_next;
  logic        ans_reg, ans_next;

  always_comb begin
    value_next = value_reg;
    count_next = count_reg;
    ans_next   = ans_reg;
    if (clr) begin
      value_next = '0;
      count_next = '0;
      ans_next   = 1'b0;
    end else if (ans) begin
      value_next = ANS_CODE;
      count_next = 3'd4;
      ans_next   = 1'b1;
    end else if (digit_en) begin
      // An ANS-loaded value is replaced by the first typed digit rather than overflowing.
      if (ans_reg) begin
        value_next = {12'h000, digit};
        count_next = 3'd1;
        ans_next   = 1'b0;
      end else if (count_reg != 3'd4) begin
        value_next = {value_reg[11:0], digit};
        count_next = count_reg + 3'd1;
      end
    end else if (bksp) begin
      if (ans_reg) begin
        value_next = '0;
        count_next = '0;
        ans_next   = 1'b0;
      end else if (count_reg != 3'd0) begin
        value_next = {4'h0, value_reg[15:4]};
        count_next = count_reg - 3'd1;
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      value_reg <= '0;
      count_reg <= '0;
      ans_reg   <= 1'b0;
    end else begin
      value_reg <= value_next;
      count_reg <= count_next;
      ans_reg   <= ans_next;
    end
  end

  assign value = value_reg;
  assign full  = (count_reg == 3'd4) && !ans_reg;
  assign empty = (count_reg == 3'd0);

endmodule

// File: rtl/operand_entry.sv
// Keypad operand entry front end: builds A, op and B, then hands them to the calculator.
// Optional backspace key enabled by defining OPERAND_ENTRY_BKSP_EN.
module operand_entry
  import calc_pkg::*;
#(
  parameter int          OPW      = AC_N,
  parameter logic [15:0] ANS_CODE = IC_ANS
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic           key_valid,
  input  logic [4:0]     key_code,
  input  logic           calc_idle,
  output logic [15:0]    SRC,
  output logic [15:0]    DST,
  output logic [OPW-1:0] ALU_OP,
  output logic           finish,
  output logic [15:0]    disp_value,
  output logic           ovf
);

  localparam logic [1:0] S_A    = 2'd0;
  localparam logic [1:0] S_B    = 2'd1;
  localparam logic [1:0] S_PEND = 2'd2;

  logic [1:0]     state_reg, state_next;
  logic [OPW-1:0] alu_op_reg, alu_op_next;
  logic [15:0]    src_reg, dst_reg;
  logic           ovf_reg;

  logic in_entry, active, active_empty, clear_op_b;
  logic digit_key, op_key, eq_key, clear_key, ans_key, bksp_key;

  logic [1:0]  acc_clr, acc_ans, acc_digit, acc_bksp, acc_edit, acc_full, acc_empty;
  logic [15:0] acc_value [2];
  logic [15:0] acc_value_next [2];

  // Keys only act while an operand is being entered; S_PEND swallows everything.
  assign in_entry  = (state_reg == S_A) || (state_reg == S_B);
  assign digit_key = key_valid && in_entry && !key_code[4];
  assign op_key    = key_valid && in_entry && is_op_key(key_code);
  assign eq_key    = key_valid && in_entry && (key_code == KC_EQUALS);
  assign clear_key = key_valid && in_entry && (key_code == KC_CLEAR);
  assign ans_key   = key_valid && in_entry && (key_code == KC_ANS);
`ifdef OPERAND_ENTRY_BKSP_EN
  assign bksp_key  = key_valid && in_entry && (key_code == KC_BKSP);
`else
  assign bksp_key  = 1'b0;
`endif

  assign active       = (state_reg == S_B);
  assign active_empty = acc_empty[active];
  assign clear_op_b   = op_key && (state_reg == S_A);
  assign finish       = (state_reg == S_PEND) && calc_idle;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_acc
      logic sel;
      assign sel = (gi == 1) ? active : !active;

      assign acc_ans[gi]   = ans_key && sel;
      assign acc_digit[gi] = digit_key && sel;
      assign acc_bksp[gi]  = bksp_key && sel;
      assign acc_clr[gi]   = clear_key || finish || ((gi == 1) && clear_op_b);
      // The post-finish clear is not an edit, so SRC/DST keep the values just handed off.
      assign acc_edit[gi]  = clear_key || acc_ans[gi] || acc_digit[gi] || acc_bksp[gi]
                             || ((gi == 1) && clear_op_b);

      digit_accum #(
        .ANS_CODE (ANS_CODE)
      ) u_acc (
        .Clock      (Clock),
        .Reset      (Reset),
        .clr        (acc_clr[gi]),
        .ans        (acc_ans[gi]),
        .digit_en   (acc_digit[gi]),
        .digit      (key_code[3:0]),
        .bksp       (acc_bksp[gi]),
        .value      (acc_value[gi]),
        .value_next (acc_value_next[gi]),
        .full       (acc_full[gi]),
        .empty      (acc_empty[gi])
      );
    end
  endgenerate

  always_comb begin
    state_next  = state_reg;
    alu_op_next = alu_op_reg;
    case (state_reg)
      S_A: begin
        if (clear_key) begin
          alu_op_next = OPW'(AC_AN);
        end else if (op_key) begin
          alu_op_next = OPW'(op_of_key(key_code));
          state_next  = S_B;
        end
      end
      S_B: begin
        if (clear_key) begin
          alu_op_next = OPW'(AC_AN);
          state_next  = S_A;
        end else if (eq_key) begin
          state_next = S_PEND;
        end else if (op_key && active_empty) begin
          alu_op_next = OPW'(op_of_key(key_code));
        end
      end
      S_PEND: begin
        if (calc_idle) state_next = S_A;
      end
      default: state_next = S_A;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_reg  <= S_A;
      alu_op_reg <= OPW'(AC_AN);
      src_reg    <= '0;
      dst_reg    <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      alu_op_reg <= alu_op_next;
      if (acc_edit[0]) src_reg <= acc_value_next[0];
      if (acc_edit[1]) dst_reg <= acc_value_next[1];
      ovf_reg    <= |(acc_digit & acc_full);
    end
  end

  assign SRC        = src_reg;
  assign DST        = dst_reg;
  assign ALU_OP     = alu_op_reg;
  assign ovf        = ovf_reg;
  assign disp_value = (state_reg == S_A) ? acc_value[0] : acc_value[1];

endmodule
